rename_register_file: RTL and testbench
=======================================

Name: rename_register_file

Overview:
- Architectural register file with per-register reservation tags, widened to multiple reserve (dispatch) ports and multiple commit (ROB retire) ports.
- Adds a global flush for misprediction recovery and an optional hardwired-zero register 0.
- Sits between the decode/dispatch stage and the ROB.
- Read ports return {tag, data} plus a filled flag, so dispatch can choose between the register value and waiting on a ROB entry.

Parameters:
- N_RD_PORTS, 3, number of combinational read ports.
- N_RSV_PORTS, 2, reservations per cycle; higher index = younger instruction.
- N_CMT_PORTS, 2, commits per cycle; higher index = younger ROB entry.
- ZERO_REG, 1, when 1, register 0 reads 0, is always filled and is never reserved or written.
- DATA_W / RSV_ID_W / REG_ADDR_W, from fcpu_pkg, data width / ROB tag width / register address width.

Ports:
- clk  in  1  clock.
- nrst  in  1  synchronous active-low reset.
- rsv  in  N_RSV_PORTS  reserve request per port.
- rsvAddr  in  N_RSV_PORTS x REG_ADDR_W  destination register to reserve.
- rsvId  in  N_RSV_PORTS x RSV_ID_W  ROB id that will produce the value.
- we  in  N_CMT_PORTS  commit valid.
- we_invalidate  in  N_CMT_PORTS  commit without data update (exception/store-type).
- wrQueAddr  in  N_CMT_PORTS x RSV_ID_W  committing ROB id.
- wrAddr  in  N_CMT_PORTS x REG_ADDR_W  committed destination register.
- wrData  in  N_CMT_PORTS x DATA_W  committed value.
- flush  in  1  discard all outstanding reservations.
- rdAddrs  in  N_RD_PORTS x REG_ADDR_W  read addresses.
- rdData  out  N_RD_PORTS x (RSV_ID_W+DATA_W)  {tag, data}, tag in the MSBs.
- rdData_filled  out  N_RD_PORTS  1 = data valid, 0 = wait on tag.
- n_pending  out  REG_ADDR_W+1  count of registers with filled=0.

Behaviour:
- Reset: on a clk edge with nrst=0, all data=0, all tags=0, all filled=1 and n_pending=0. This overrides every other input in that cycle.
- Reads:
  - Combinational from current state: zero-cycle latency, no read-during-write visibility.
  - With ZERO_REG=1 and address 0, the port returns {0,0} with filled=1.
- Commit port k, when we[k]=1 (all effects at the next edge):
  - Data: if we_invalidate[k]=0, data[wrAddr[k]] is written with wrData[k]. This happens regardless of the tag.
  - Filled: if the stored tag of wrAddr[k] equals wrQueAddr[k], filled is set to 1. This applies even when invalidate is set.
  - Tag mismatch (the register was re-reserved by a younger instruction): data is still written, filled is unchanged.
- Same-cycle commits to one register: the highest index port wins for data. Filled is set if any matching port matches the tag.
- Reserve port j, when rsv[j]=1: at the next edge, tag[rsvAddr[j]] <= rsvId[j] and filled <= 0. Same-cycle reserves to one register: the highest index wins.
- Reserve vs commit to the same register in the same cycle: reserve wins for tag and filled; commit still updates data.
- ZERO_REG=1: reserves and commits to register 0 are ignored.
- Flush=1 at an edge:
  - All filled <= 1 and all tags <= 0.
  - Every rsv in that cycle is ignored.
  - Commits in that cycle still write data.
- n_pending:
  - Registered, equal to the population count of ~filled after each edge; never exceeds 2**REG_ADDR_W.
  - Returns to 0 the edge after a flush or reset.
- Filled state per register is a 2-state machine:
  - FILLED -> PENDING on reserve.
  - PENDING -> FILLED on tag-matched commit or flush.
  - PENDING -> PENDING (new tag) on re-reserve.

Optional Feature:
- Macro: FCPU_REGFILE_BYPASS_EN.
- Defined:
  - A read port whose address matches a same-cycle commit (we=1, we_invalidate=0, tag match against the current stored tag) returns wrData with filled=1.
  - Among multiple matching commits, the highest index wins.
  - Reserve ports are never bypassed.
- Undefined: reads reflect registered state only. The commit becomes visible one cycle later.

Test Plan:
- Reset, then read r5 -> {tag 0, data 0}, filled=1, n_pending=0.
- Reserve r3 with id 7; next cycle read r3 -> tag 7, filled=0, n_pending=1. Commit r3 id 7 data 0xDEADBEEF; next cycle -> data 0xDEADBEEF, filled=1, n_pending=0.
- Reserve r4 id 2, then r4 id 9 (WAW); commit r4 id 2 data 0x11 -> data 0x11, filled=0, tag 9. Commit id 9 data 0x22 -> filled=1.
- Same cycle: rsv port0 r6 id 1 and rsv port1 r6 id 4 -> tag 4. Commit ports 0/1 both to r8 with data 0xA / 0xB -> data 0xB.
- Reserve r1, r2, r10 (n_pending=3); flush together with rsv r12 -> all filled=1, r12 not reserved, n_pending=0. Writing r0 with 0x5 under ZERO_REG=1 -> r0 still reads 0.
- With FCPU_REGFILE_BYPASS_EN: r7 reserved id 3; commit r7 id 3 data 0x77 while reading r7 -> same cycle returns 0x77, filled=1. Without the macro -> filled=0 that cycle, 0x77 the next.

Source files
------------

// File: rtl/rename_register_file.sv
// rename_register_file: architectural register file with per-register
// reservation tags, multiple reserve (dispatch) ports, multiple commit
// (ROB retire) ports, global flush and optional hardwired-zero register 0.
// Optional feature macro: FCPU_REGFILE_BYPASS_EN (same-cycle commit bypass
// onto the read ports). Default build leaves it disabled.

package fcpu_pkg;
  parameter int DATA_W     = 32;
  parameter int RSV_ID_W   = 5;
  parameter int REG_ADDR_W = 5;
endpackage

module rename_register_file
  import fcpu_pkg::*;
#(
  parameter int N_RD_PORTS  = 3,
  parameter int N_RSV_PORTS = 2,
  parameter int N_CMT_PORTS = 2,
  parameter int ZERO_REG    = 1
) (
  input  logic                                           clk,
  input  logic                                           nrst,
  input  logic [N_RSV_PORTS-1:0]                         rsv,
  input  logic [N_RSV_PORTS-1:0][REG_ADDR_W-1:0]         rsvAddr,
  input  logic [N_RSV_PORTS-1:0][RSV_ID_W-1:0]           rsvId,
  input  logic [N_CMT_PORTS-1:0]                         we,
  input  logic [N_CMT_PORTS-1:0]                         we_invalidate,
  input  logic [N_CMT_PORTS-1:0][RSV_ID_W-1:0]           wrQueAddr,
  input  logic [N_CMT_PORTS-1:0][REG_ADDR_W-1:0]         wrAddr,
  input  logic [N_CMT_PORTS-1:0][DATA_W-1:0]             wrData,
  input  logic                                           flush,
  input  logic [N_RD_PORTS-1:0][REG_ADDR_W-1:0]          rdAddrs,
  output logic [N_RD_PORTS-1:0][RSV_ID_W+DATA_W-1:0]     rdData,
  output logic [N_RD_PORTS-1:0]                          rdData_filled,
  output logic [REG_ADDR_W:0]                            n_pending
);

  localparam int N_REGS = 1 << REG_ADDR_W;

  logic [DATA_W-1:0]   data_reg   [N_REGS];
  logic [DATA_W-1:0]   data_next  [N_REGS];
  logic [RSV_ID_W-1:0] tag_reg    [N_REGS];
  logic [RSV_ID_W-1:0] tag_next   [N_REGS];
  logic                filled_reg [N_REGS];
  logic                filled_next[N_REGS];
  logic [REG_ADDR_W:0] n_pending_reg;
  logic [REG_ADDR_W:0] n_pending_next;

  // Next state per register: commits update data/filled, then reserves
  // (younger than any retiring instruction) override tag and filled; flush
  // drops every reservation but lets same-cycle commits still write data.
  always_comb begin
    for (int r = 0; r < N_REGS; r++) begin
      data_next[r]   = data_reg[r];
      tag_next[r]    = tag_reg[r];
      filled_next[r] = filled_reg[r];
      if ((ZERO_REG != 0) && (r == 0)) begin
        data_next[r]   = '0;
        tag_next[r]    = '0;
        filled_next[r] = 1'b1;
      end else begin
        // Higher commit index overrides lower for data; any tag match fills.
        for (int k = 0; k < N_CMT_PORTS; k++) begin
          if (we[k] && (wrAddr[k] == REG_ADDR_W'(r))) begin
            if (!we_invalidate[k]) begin
              data_next[r] = wrData[k];
            end
            if (tag_reg[r] == wrQueAddr[k]) begin
              filled_next[r] = 1'b1;
            end
          end
        end
        if (flush) begin
          tag_next[r]    = '0;
          filled_next[r] = 1'b1;
        end else begin
          // Higher reserve index is the younger instruction and wins.
          for (int j = 0; j < N_RSV_PORTS; j++) begin
            if (rsv[j] && (rsvAddr[j] == REG_ADDR_W'(r))) begin
              tag_next[r]    = rsvId[j];
              filled_next[r] = 1'b0;
            end
          end
        end
      end
    end
  end

  // Population count of pending registers after the coming edge.
  always_comb begin
    n_pending_next = '0;
    for (int r = 0; r < N_REGS; r++) begin
      n_pending_next = n_pending_next + {{REG_ADDR_W{1'b0}}, ~filled_next[r]};
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int r = 0; r < N_REGS; r++) begin
        data_reg[r]   <= '0;
        tag_reg[r]    <= '0;
        filled_reg[r] <= 1'b1;
      end
      n_pending_reg <= '0;
    end else begin
      for (int r = 0; r < N_REGS; r++) begin
        data_reg[r]   <= data_next[r];
        tag_reg[r]    <= tag_next[r];
        filled_reg[r] <= filled_next[r];
      end
      n_pending_reg <= n_pending_next;
    end
  end

  assign n_pending = n_pending_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_RD_PORTS; gi++) begin : g_rd
      logic [RSV_ID_W-1:0] rd_tag;
      logic [DATA_W-1:0]   rd_dat;
      logic                rd_fil;

      // Combinational read of current state, with optional commit bypass.
      always_comb begin
        rd_tag = tag_reg[rdAddrs[gi]];
        rd_dat = data_reg[rdAddrs[gi]];
        rd_fil = filled_reg[rdAddrs[gi]];
`ifdef FCPU_REGFILE_BYPASS_EN
        for (int k = 0; k < N_CMT_PORTS; k++) begin
          if (we[k] && !we_invalidate[k] && (wrAddr[k] == rdAddrs[gi]) &&
              (wrQueAddr[k] == tag_reg[rdAddrs[gi]])) begin
            rd_dat = wrData[k];
            rd_fil = 1'b1;
          end
        end
`endif
        if ((ZERO_REG != 0) && (rdAddrs[gi] == '0)) begin
          rd_tag = '0;
          rd_dat = '0;
          rd_fil = 1'b1;
        end
      end

      assign rdData[gi]        = {rd_tag, rd_dat};
      assign rdData_filled[gi] = rd_fil;
    end
  endgenerate

endmodule

// File: tb/tb_rename_register_file.sv
// Testbench for rename_register_file: directed vectors, expected responses
// pushed into a scoreboard queue and checked by a separate monitor.
module tb_rename_register_file;
  import fcpu_pkg::*;

  localparam int NRD = 3;
  localparam int NRS = 2;
  localparam int NCM = 2;

  logic                               clk;
  logic                               nrst;
  logic [NRS-1:0]                     rsv;
  logic [NRS-1:0][REG_ADDR_W-1:0]     rsvAddr;
  logic [NRS-1:0][RSV_ID_W-1:0]       rsvId;
  logic [NCM-1:0]                     we;
  logic [NCM-1:0]                     we_invalidate;
  logic [NCM-1:0][RSV_ID_W-1:0]       wrQueAddr;
  logic [NCM-1:0][REG_ADDR_W-1:0]     wrAddr;
  logic [NCM-1:0][DATA_W-1:0]         wrData;
  logic                               flush;
  logic [NRD-1:0][REG_ADDR_W-1:0]     rdAddrs;
  logic [NRD-1:0][RSV_ID_W+DATA_W-1:0] rdData;
  logic [NRD-1:0]                     rdData_filled;
  logic [REG_ADDR_W:0]                n_pending;

  rename_register_file #(
    .N_RD_PORTS(NRD), .N_RSV_PORTS(NRS), .N_CMT_PORTS(NCM), .ZERO_REG(1)
  ) dut (
    .clk(clk), .nrst(nrst), .rsv(rsv), .rsvAddr(rsvAddr), .rsvId(rsvId),
    .we(we), .we_invalidate(we_invalidate), .wrQueAddr(wrQueAddr),
    .wrAddr(wrAddr), .wrData(wrData), .flush(flush), .rdAddrs(rdAddrs),
    .rdData(rdData), .rdData_filled(rdData_filled), .n_pending(n_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                  cyc;
    int                  kind;   // 0 = read port, 1 = n_pending
    int                  port;
    logic [RSV_ID_W-1:0] tag;
    logic [DATA_W-1:0]   data;
    logic                fil;
    int                  np;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic clr();
    nrst = 1'b1; rsv = '0; rsvAddr = '0; rsvId = '0;
    we = '0; we_invalidate = '0; wrQueAddr = '0; wrAddr = '0; wrData = '0;
    flush = 1'b0; rdAddrs = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
    cyc++;
  endtask

  task automatic rd(input int port, input int addr, input int tag,
                    input logic [DATA_W-1:0] data, input logic fil);
    exp_t e;
    rdAddrs[port] = REG_ADDR_W'(addr);
    e.cyc = cyc; e.kind = 0; e.port = port; e.tag = RSV_ID_W'(tag);
    e.data = data; e.fil = fil; e.np = 0;
    sb.push_back(e);
  endtask

  task automatic np(input int n);
    exp_t e;
    e.cyc = cyc; e.kind = 1; e.port = 0; e.tag = '0; e.data = '0;
    e.fil = 1'b0; e.np = n;
    sb.push_back(e);
  endtask

  task automatic rsv_drv(input int port, input int addr, input int id);
    rsv[port] = 1'b1;
    rsvAddr[port] = REG_ADDR_W'(addr);
    rsvId[port] = RSV_ID_W'(id);
  endtask

  task automatic cmt(input int port, input int addr, input int id,
                     input logic [DATA_W-1:0] data, input logic inv);
    we[port] = 1'b1;
    we_invalidate[port] = inv;
    wrAddr[port] = REG_ADDR_W'(addr);
    wrQueAddr[port] = RSV_ID_W'(id);
    wrData[port] = data;
  endtask

  // Monitor: drain every expectation queued for this cycle, mid-cycle.
  always @(negedge clk) begin
    exp_t                e;
    logic [RSV_ID_W-1:0] g_tag;
    logic [DATA_W-1:0]   g_dat;
    logic                g_fil;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (e.kind == 0) begin
        g_tag = rdData[e.port][RSV_ID_W+DATA_W-1 -: RSV_ID_W];
        g_dat = rdData[e.port][DATA_W-1:0];
        g_fil = rdData_filled[e.port];
        if (g_tag !== e.tag || g_dat !== e.data || g_fil !== e.fil) begin
          errors++;
          $display("FAIL rd cyc=%0d port%0d addr=%0d: got tag=%0d data=%h filled=%0b, expected tag=%0d data=%h filled=%0b",
                   e.cyc, e.port, rdAddrs[e.port], g_tag, g_dat, g_fil, e.tag, e.data, e.fil);
        end else begin
          $display("ok rd cyc=%0d port%0d addr=%0d tag=%0d data=%h filled=%0b",
                   e.cyc, e.port, rdAddrs[e.port], g_tag, g_dat, g_fil);
        end
      end else begin
        if (n_pending !== (REG_ADDR_W+1)'(e.np)) begin
          errors++;
          $display("FAIL n_pending cyc=%0d: got %0d, expected %0d", e.cyc, n_pending, e.np);
        end else begin
          $display("ok n_pending cyc=%0d = %0d", e.cyc, n_pending);
        end
      end
    end
  end

  // Hard time bound in case the bench stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    // C0: reset state
    rd(0, 5, 0, 32'h0, 1'b1); np(0); rsv_drv(0, 3, 7);
    step(); // C1: r3 reserved by id 7
    rd(0, 3, 7, 32'h0, 1'b0); np(1);
    step(); // C2: commit r3 id 7
    cmt(0, 3, 7, 32'hDEADBEEF, 1'b0); rd(1, 0, 0, 32'h0, 1'b1);
    step(); // C3
    rd(0, 3, 7, 32'hDEADBEEF, 1'b1); np(0); rsv_drv(0, 4, 2);
    step(); // C4: WAW re-reserve r4
    rsv_drv(0, 4, 9); rd(0, 4, 2, 32'h0, 1'b0); np(1);
    step(); // C5: stale commit id 2
    cmt(0, 4, 2, 32'h11, 1'b0); rd(0, 4, 9, 32'h0, 1'b0); np(1);
    step(); // C6: data written, still pending
    rd(0, 4, 9, 32'h11, 1'b0); np(1);
    step(); // C7: matching commit, dual reserve to r6
    cmt(0, 4, 9, 32'h22, 1'b0); rsv_drv(0, 6, 1); rsv_drv(1, 6, 4);
    rd(0, 5, 0, 32'h0, 1'b1);
    step(); // C8: dual commit to r8
    rd(0, 4, 9, 32'h22, 1'b1); rd(1, 6, 4, 32'h0, 1'b0); np(1);
    cmt(0, 8, 0, 32'hA, 1'b0); cmt(1, 8, 0, 32'hB, 1'b0);
    step(); // C9
    rd(0, 8, 0, 32'hB, 1'b1); np(1);
    rsv_drv(0, 1, 1); rsv_drv(1, 2, 2); cmt(0, 6, 4, 32'h66, 1'b0);
    step(); // C10
    rsv_drv(0, 10, 10); rd(0, 1, 1, 32'h0, 1'b0); rd(1, 6, 4, 32'h66, 1'b1); np(2);
    step(); // C11: flush with reserve r12, commits to r0 and r9
    np(3); rd(0, 10, 10, 32'h0, 1'b0);
    flush = 1'b1; rsv_drv(0, 12, 12);
    cmt(0, 0, 0, 32'h5, 1'b0); cmt(1, 9, 0, 32'h99, 1'b0);
    step(); // C12
    np(0); rd(0, 12, 0, 32'h0, 1'b1); rd(1, 10, 0, 32'h0, 1'b1); rd(2, 0, 0, 32'h0, 1'b1);
    step(); // C13
    rd(0, 9, 0, 32'h99, 1'b1); rd(1, 1, 0, 32'h0, 1'b1); rsv_drv(0, 7, 3);
    step(); // C14: commit r7 while reading it
    np(1); cmt(0, 7, 3, 32'h77, 1'b0);
`ifdef FCPU_REGFILE_BYPASS_EN
    rd(0, 7, 3, 32'h77, 1'b1);
`else
    rd(0, 7, 3, 32'h0, 1'b0);
`endif
    step(); // C15
    rd(0, 7, 3, 32'h77, 1'b1); np(0); rsv_drv(0, 11, 5);
    step(); // C16: invalidating commit
    cmt(0, 11, 5, 32'hBAD, 1'b1); rd(0, 11, 5, 32'h0, 1'b0); np(1);
    step(); // C17: reserve and commit same register
    rd(0, 11, 5, 32'h0, 1'b1); np(0);
    rsv_drv(0, 13, 6); cmt(0, 13, 0, 32'h13, 1'b0);
    step(); // C18: reset overrides reserve
    rd(0, 13, 6, 32'h13, 1'b0); np(1);
    nrst = 1'b0; rsv_drv(0, 14, 1);
    step(); // C19
    rd(0, 13, 0, 32'h0, 1'b1); rd(1, 14, 0, 32'h0, 1'b1); np(0);
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
